pmem_pf_arbiter: RTL and testbench

Physical-memory arbiter with an integrated next-line prefetch engine. It sits between the instruction cache, the data cache and `prefetch_buffer` on one side and the single 256-bit physical memory port on the other. It serialises line transfers and schedules next-line prefetches into idle memory slots, delivering prefetched lines to the buffer via a load strobe.

---
 rtl/pmem_pf_arbiter_pkg.sv | 31 +++
 rtl/pmem_pf_arbiter_if.sv | 49 ++++
 rtl/pmem_pf_arbiter_nl_addr_gen.sv | 52 +++++
 rtl/pmem_pf_arbiter.sv | 130 +++++++++++++
 tb/tb_pmem_pf_arbiter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmem_pf_arbiter_pkg.sv
// Shared types and geometry for the physical-memory arbiter and its next-line prefetcher.
// Lines are 32 bytes and pages 4 KiB, so a page holds 128 lines.
package pf_arb_pkg;

   localparam int PMEM_ADDR_W = 32;
   localparam int PMEM_LINE_W = 256;
   localparam int LINE_BYTES  = 32;
   localparam int OFFSET_W    = $clog2(LINE_BYTES);
   localparam int PAGE_LINE_W = 7;
   localparam int LIDX_W      = PMEM_ADDR_W - OFFSET_W;

   typedef enum logic [2:0] {
      IDLE,
      D_RD,
      D_WR,
      I_FILL,
      PF_FILL,
      RESP
   } pf_arb_state_t;

   typedef enum logic [1:0] {
      SRC_D,
      SRC_I,
      SRC_PF
   } pf_arb_src_t;

   function automatic logic [LIDX_W-1:0] line_of(input logic [PMEM_ADDR_W-1:0] addr);
      return addr[PMEM_ADDR_W-1:OFFSET_W];
   endfunction

endpackage

// File: rtl/pmem_pf_arbiter_if.sv
// Bundle of cache-side, prefetch-buffer and memory-side signals around the arbiter.
// The slave modport is the arbiter; the master modport is everything around it.
interface pmem_pf_arbiter_if
   import pf_arb_pkg::*;
#(
   parameter int ADDR_W = PMEM_ADDR_W,
   parameter int LINE_W = PMEM_LINE_W
);

   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic              i_pf_hit;
   logic              i_resp;
   logic [LINE_W-1:0] i_rdata;

   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic              d_resp;
   logic [LINE_W-1:0] d_rdata;

   logic [ADDR_W-1:0] pf_addr;
   logic              pf_write;
   logic              pf_ld;
   logic [LINE_W-1:0] pf_rdata;

   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_addr;
   logic [LINE_W-1:0] pmem_wdata;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;

   modport slave (
      input  i_read, i_addr, i_pf_hit, d_read, d_write, d_addr, d_wdata,
             pmem_rdata, pmem_resp,
      output i_resp, i_rdata, d_resp, d_rdata, pf_addr, pf_write, pf_ld,
             pf_rdata, pmem_read, pmem_write, pmem_addr, pmem_wdata
   );

   modport master (
      output i_read, i_addr, i_pf_hit, d_read, d_write, d_addr, d_wdata,
             pmem_rdata, pmem_resp,
      input  i_resp, i_rdata, d_resp, d_rdata, pf_addr, pf_write, pf_ld,
             pf_rdata, pmem_read, pmem_write, pmem_addr, pmem_wdata
   );

endinterface

// File: rtl/pmem_pf_arbiter_nl_addr_gen.sv
// Next-line prefetch address generator: remembers the line after the last icache fill
// and whether it is still worth fetching.
module nl_addr_gen
   import pf_arb_pkg::*;
#(
   parameter int IDX_W = LIDX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             done_i,
   input  logic [IDX_W-1:0] doneLine_i,
   input  logic             take_i,
   input  logic             dWrite_i,
   input  logic [IDX_W-1:0] dLine_i,
   output logic             pending_o,
   output logic [IDX_W-1:0] next_o
);

   logic             pending_q, pending_d;
   logic [IDX_W-1:0] next_q, next_d;

   // A fresh fill completion overrides a stale-clear in the same cycle; a fill on the
   // last line of a page cancels prefetching instead of crossing into the next page.
   always_comb begin
      pending_d = pending_q;
      next_d    = next_q;
      if (dWrite_i && (dLine_i == next_q)) pending_d = 1'b0;
      if (take_i) pending_d = 1'b0;
      if (done_i) begin
         if (&doneLine_i[PAGE_LINE_W-1:0]) begin
            pending_d = 1'b0;
         end else begin
            next_d    = doneLine_i + IDX_W'(1);
            pending_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= 1'b0;
         next_q    <= '0;
      end else begin
         pending_q <= pending_d;
         next_q    <= next_d;
      end
   end

   assign pending_o = pending_q;
   assign next_o    = next_q;

endmodule

// File: rtl/pmem_pf_arbiter.sv
// Serialises dcache, icache and next-line prefetch traffic onto one line-wide memory port.
// Outputs are decoded from registered state, so commands and resp pulses are glitch-free.
module pmem_pf_arbiter
   import pf_arb_pkg::*;
#(
   parameter int ADDR_W = PMEM_ADDR_W,
   parameter int LINE_W = PMEM_LINE_W
) (
   input logic               clk,
   input logic               rst,
   pmem_pf_arbiter_if.slave  bus
);

   localparam int IDX_W = ADDR_W - OFFSET_W;

   pf_arb_state_t     state_q, state_d;
   pf_arb_src_t       src_q, src_d;
   logic [IDX_W-1:0]  reqLine_q, reqLine_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic [LINE_W-1:0] lineData_q, lineData_d;
   logic              merge_q, merge_d;

   logic              pfPending;
   logic [IDX_W-1:0]  pfNext;
   logic              pfTake;
   logic              inResp;
   logic              pfWrite;
   logic              iResp;
   logic [ADDR_W-1:0] lineAddr;

   nl_addr_gen #(.IDX_W(IDX_W)) u_nl_addr_gen (
      .clk        (clk),
      .rst        (rst),
      .done_i     (iResp),
      .doneLine_i (reqLine_q),
      .take_i     (pfTake),
      .dWrite_i   (bus.d_write),
      .dLine_i    (line_of(bus.d_addr)),
      .pending_o  (pfPending),
      .next_o     (pfNext)
   );

   // Fixed-priority arbitration in IDLE; a transaction then owns memory until pmem_resp.
   // An icache read for the line already being prefetched rides along as a merge.
   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      reqLine_d  = reqLine_q;
      wdata_d    = wdata_q;
      lineData_d = lineData_q;
      merge_d    = merge_q;
      pfTake     = 1'b0;
      case (state_q)
         IDLE: begin
            merge_d = 1'b0;
            if (bus.d_write) begin
               state_d   = D_WR;
               src_d     = SRC_D;
               reqLine_d = line_of(bus.d_addr);
               wdata_d   = bus.d_wdata;
            end else if (bus.d_read) begin
               state_d   = D_RD;
               src_d     = SRC_D;
               reqLine_d = line_of(bus.d_addr);
            end else if (bus.i_read && !bus.i_pf_hit) begin
               state_d   = I_FILL;
               src_d     = SRC_I;
               reqLine_d = line_of(bus.i_addr);
            end else if (pfPending) begin
               state_d   = PF_FILL;
               src_d     = SRC_PF;
               reqLine_d = pfNext;
               pfTake    = 1'b1;
            end
         end
         D_RD, D_WR, I_FILL, PF_FILL: begin
            if ((state_q == PF_FILL) && bus.i_read && !bus.i_pf_hit &&
                (line_of(bus.i_addr) == reqLine_q)) begin
               merge_d = 1'b1;
            end
            if (bus.pmem_resp) begin
               lineData_d = bus.pmem_rdata;
               state_d    = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
            merge_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         src_q      <= SRC_D;
         reqLine_q  <= '0;
         wdata_q    <= '0;
         lineData_q <= '0;
         merge_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         reqLine_q  <= reqLine_d;
         wdata_q    <= wdata_d;
         lineData_q <= lineData_d;
         merge_q    <= merge_d;
      end
   end

   assign inResp   = (state_q == RESP);
   assign iResp    = inResp && ((src_q == SRC_I) || ((src_q == SRC_PF) && merge_q));
   assign pfWrite  = (state_q == PF_FILL) || (inResp && (src_q == SRC_PF));
   assign lineAddr = {reqLine_q, {OFFSET_W{1'b0}}};

   assign bus.pmem_read  = (state_q == D_RD) || (state_q == I_FILL) || (state_q == PF_FILL);
   assign bus.pmem_write = (state_q == D_WR);
   assign bus.pmem_addr  = lineAddr;
   assign bus.pmem_wdata = wdata_q;
   assign bus.d_resp     = inResp && (src_q == SRC_D);
   assign bus.d_rdata    = lineData_q;
   assign bus.i_resp     = iResp;
   assign bus.i_rdata    = lineData_q;
   assign bus.pf_ld      = inResp && (src_q == SRC_PF);
   assign bus.pf_write   = pfWrite;
   assign bus.pf_addr    = pfWrite ? lineAddr : '0;
   assign bus.pf_rdata   = lineData_q;

endmodule

// File: tb/tb_pmem_pf_arbiter.sv
// Scoreboard bench for pmem_pf_arbiter: directed requests push expected memory commands
// and completions; a negedge monitor pops and compares them as the DUT produces them.
module tb_pmem_pf_arbiter;
   import pf_arb_pkg::*;

   typedef enum logic [1:0] {EV_RD, EV_WR, EV_RESP} evKind_t;

   typedef struct {
      evKind_t      kind;
      logic [31:0]  addr;
      logic [255:0] data;
      logic         dr;
      logic         ir;
      logic         pl;
      logic         chkData;
   } ev_t;

   ev_t  sbQueue[$];
   int   checks = 0;
   int   failures = 0;
   int   memLatency = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;

   pmem_pf_arbiter_if bus ();

   pmem_pf_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] lineData(input logic [31:0] a);
      return {8{a ^ 32'hC0DE_0000}};
   endfunction

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic void expRd(input logic [31:0] a);
      ev_t e;
      e.kind = EV_RD; e.addr = a; e.data = '0;
      e.dr = 1'b0; e.ir = 1'b0; e.pl = 1'b0; e.chkData = 1'b0;
      sbQueue.push_back(e);
   endfunction

   function automatic void expWr(input logic [31:0] a, input logic [255:0] d);
      ev_t e;
      e.kind = EV_WR; e.addr = a; e.data = d;
      e.dr = 1'b0; e.ir = 1'b0; e.pl = 1'b0; e.chkData = 1'b1;
      sbQueue.push_back(e);
   endfunction

   function automatic void expResp(input logic dr, input logic ir, input logic pl,
                                   input logic [31:0] a, input logic [255:0] d, input logic chk);
      ev_t e;
      e.kind = EV_RESP; e.addr = a; e.data = d;
      e.dr = dr; e.ir = ir; e.pl = pl; e.chkData = chk;
      sbQueue.push_back(e);
   endfunction

   // Zero-wait-capable memory: answers after memLatency cycles of a held command.
   initial begin
      int cnt;
      cnt = 0;
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
      forever begin
         @(negedge clk);
         bus.pmem_resp = 1'b0;
         if (rst) begin
            cnt = 0;
         end else if (bus.pmem_read || bus.pmem_write) begin
            if (cnt >= memLatency - 1) begin
               bus.pmem_resp  = 1'b1;
               bus.pmem_rdata = lineData(bus.pmem_addr);
               cnt = 0;
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Monitor: every new memory command and every completion pulse must match the queue head.
   initial begin
      logic prevRd;
      logic prevWr;
      ev_t  e;
      prevRd = 1'b0;
      prevWr = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prevRd = 1'b0;
            prevWr = 1'b0;
         end else begin
            checkOutput("cmdExclusive", 256'(bus.pmem_read & bus.pmem_write), 256'(0));
            if ((bus.pmem_read && !prevRd) || (bus.pmem_write && !prevWr)) begin
               if (sbQueue.size() == 0) begin
                  checks++; failures++;
                  $display("[TB] FAIL unexpectedCmd: got rd=%0b wr=%0b addr=%h, expected no command",
                           bus.pmem_read, bus.pmem_write, bus.pmem_addr);
               end else begin
                  e = sbQueue.pop_front();
                  checkOutput("cmdKind", 256'({bus.pmem_write, bus.pmem_read}),
                              256'((e.kind == EV_WR) ? 2'b10 : (e.kind == EV_RD) ? 2'b01 : 2'b00));
                  checkOutput("cmdAddr", 256'(bus.pmem_addr), 256'(e.addr));
                  if (e.kind == EV_WR) checkOutput("cmdWdata", bus.pmem_wdata, e.data);
               end
            end
            if (bus.d_resp || bus.i_resp || bus.pf_ld) begin
               if (sbQueue.size() == 0) begin
                  checks++; failures++;
                  $display("[TB] FAIL unexpectedResp: got d=%0b i=%0b pf=%0b, expected no completion",
                           bus.d_resp, bus.i_resp, bus.pf_ld);
               end else begin
                  e = sbQueue.pop_front();
                  checkOutput("respKind", 256'({bus.d_resp, bus.i_resp, bus.pf_ld}),
                              256'({e.dr, e.ir, e.pl}));
                  if (e.chkData && e.dr) checkOutput("dRdata", bus.d_rdata, e.data);
                  if (e.chkData && e.ir) checkOutput("iRdata", bus.i_rdata, e.data);
                  if (e.chkData && e.pl) checkOutput("pfRdata", bus.pf_rdata, e.data);
                  if (e.pl) begin
                     checkOutput("pfAddr", 256'(bus.pf_addr), 256'(e.addr));
                     checkOutput("pfWriteAtLd", 256'(bus.pf_write), 256'(1));
                  end
               end
            end
            prevRd = bus.pmem_read;
            prevWr = bus.pmem_write;
         end
      end
   end

   // Raises a request now (caller sits on a negedge), waits for its completion, drops it.
   task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [255:0] wdata,
                                output int lat);
      logic got;
      got = 1'b0;
      lat = 0;
      if (kind == 0) begin
         bus.i_addr = addr; bus.i_read = 1'b1;
      end else if (kind == 1) begin
         bus.d_addr = addr; bus.d_read = 1'b1;
      end else begin
         bus.d_addr = addr; bus.d_wdata = wdata; bus.d_write = 1'b1;
      end
      for (int n = 1; n <= 300 && !got; n++) begin
         @(negedge clk);
         got = (kind == 0) ? bus.i_resp : bus.d_resp;
         lat = n;
      end
      if (kind == 0) bus.i_read = 1'b0;
      else if (kind == 1) bus.d_read = 1'b0;
      else bus.d_write = 1'b0;
      checkOutput("respTimeout", 256'(got), 256'(1));
   endtask

   task automatic waitPfLd(input string name, input int budget);
      logic got;
      got = 1'b0;
      for (int n = 0; n < budget && !got; n++) begin
         @(negedge clk);
         got = bus.pf_ld;
      end
      checkOutput(name, 256'(got), 256'(1));
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   lat;
      int   latA;
      int   latB;
      logic seen;
      bus.i_read = 1'b0; bus.i_addr = '0; bus.i_pf_hit = 1'b0;
      bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      repeat (3) @(negedge clk);
      checkOutput("rstCtrl", 256'({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp,
                                   bus.pf_ld, bus.pf_write}), 256'(0));
      checkOutput("rstPmemAddr", 256'(bus.pmem_addr), 256'(0));
      checkOutput("rstRdata", bus.i_rdata, 256'(0));
      rst = 1'b0;
      @(negedge clk);

      // Icache miss, then the next line is prefetched into the buffer.
      memLatency = 4;
      expRd(32'h0000_1040); expResp(1'b0, 1'b1, 1'b0, 32'h0000_1040, lineData(32'h0000_1040), 1'b1);
      expRd(32'h0000_1060); expResp(1'b0, 1'b0, 1'b1, 32'h0000_1060, lineData(32'h0000_1060), 1'b1);
      applyStimulus(0, 32'h0000_1040, '0, lat);
      waitPfLd("tc1PfLd", 50);
      repeat (3) @(negedge clk);

      // Last line of a page: no prefetch may follow.
      expRd(32'h0000_1FE0); expResp(1'b0, 1'b1, 1'b0, 32'h0000_1FE0, lineData(32'h0000_1FE0), 1'b1);
      applyStimulus(0, 32'h0000_1FE0, '0, lat);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen = seen | bus.pf_write | bus.pmem_read;
      end
      checkOutput("tc2NoPrefetch", 256'(seen), 256'(0));

      // Dcache write beats a simultaneous icache read; a write to the queued next line kills it.
      memLatency = 3;
      expWr(32'h0000_3000, {8{32'hDEAD_BEEF}}); expResp(1'b1, 1'b0, 1'b0, 32'h0, '0, 1'b0);
      expRd(32'h0000_4000); expResp(1'b0, 1'b1, 1'b0, 32'h0000_4000, lineData(32'h0000_4000), 1'b1);
      fork
         applyStimulus(2, 32'h0000_3000, {8{32'hDEAD_BEEF}}, latA);
         applyStimulus(0, 32'h0000_4000, '0, latB);
      join
      checkOutput("tc3DcacheFirst", 256'(latA < latB), 256'(1));
      expWr(32'h0000_4020, {8{32'h1234_5678}}); expResp(1'b1, 1'b0, 1'b0, 32'h0, '0, 1'b0);
      applyStimulus(2, 32'h0000_4020, {8{32'h1234_5678}}, lat);
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         seen = seen | bus.pf_write | bus.pmem_read;
      end
      checkOutput("tc3StaleNoPf", 256'(seen), 256'(0));

      // Icache read for the line being prefetched merges into the in-flight fill.
      memLatency = 6;
      expRd(32'h0000_2040); expResp(1'b0, 1'b1, 1'b0, 32'h0000_2040, lineData(32'h0000_2040), 1'b1);
      expRd(32'h0000_2060); expResp(1'b0, 1'b1, 1'b1, 32'h0000_2060, lineData(32'h0000_2060), 1'b1);
      expRd(32'h0000_2080); expResp(1'b0, 1'b0, 1'b1, 32'h0000_2080, lineData(32'h0000_2080), 1'b1);
      applyStimulus(0, 32'h0000_2040, '0, lat);
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         seen = bus.pf_write;
      end
      checkOutput("tc4PfStarted", 256'(seen), 256'(1));
      applyStimulus(0, 32'h0000_2064, '0, lat);
      waitPfLd("tc4NextPfLd", 60);
      repeat (3) @(negedge clk);

      // Prefetch-buffer hit suppresses the icache request entirely.
      memLatency = 2;
      bus.i_pf_hit = 1'b1; bus.i_addr = 32'h0000_6000; bus.i_read = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen = seen | bus.pmem_read | bus.pmem_write | bus.i_resp;
      end
      bus.i_read = 1'b0; bus.i_pf_hit = 1'b0;
      checkOutput("tc5PfHitQuiet", 256'(seen), 256'(0));

      // Reset in the middle of a dcache read abandons it; the next request is served normally.
      memLatency = 10;
      expRd(32'h0000_7000);
      bus.d_addr = 32'h0000_7000; bus.d_read = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("tc6InDrd", 256'(bus.pmem_read), 256'(1));
      rst = 1'b1;
      #1;
      checkOutput("tc6RstCtrl", 256'({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp,
                                      bus.pf_ld, bus.pf_write}), 256'(0));
      checkOutput("tc6RstAddr", 256'(bus.pmem_addr), 256'(0));
      bus.d_read = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      memLatency = 1;
      expRd(32'h0000_5000); expResp(1'b1, 1'b0, 1'b0, 32'h0, lineData(32'h0000_5000), 1'b1);
      applyStimulus(1, 32'h0000_5013, '0, lat);
      // Request cycle, command cycle, then resp cycle: two negedges after the request.
      checkOutput("tc6MinLatency", 256'(lat), 256'(2));

      repeat (5) @(negedge clk);
      checkOutput("sbDrained", 256'(sbQueue.size()), 256'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
